// File: rtl/post_normal.sv
// Post-normalizer for binary32 add/sub: iterative renormalization, rounding and packing.
// Define POST_NORMAL_RNE_EN for round-to-nearest-even; otherwise rounds toward zero.
module post_normal #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  logic                     sign_i,
   input  logic [EXP_W-1:0]         exp_i,
   input  logic [MAN_W+1:0]         mant_i,
   input  logic [2:0]               grs_i,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [EXP_W+MAN_W:0]     result_o,
   output logic                     overflow_o,
   output logic                     underflow_o,
   output logic                     inexact_o
);

   localparam int RES_W = 1 + EXP_W + MAN_W;
   localparam int SH_W  = $clog2(MAN_W + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_NORM  = 2'd1;
   localparam logic [1:0] S_ROUND = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [EXP_W:0]   EXP_MAX  = {1'b0, EXP_ONES};
   localparam logic [EXP_W:0]   EXP_ONE  = (EXP_W+1)'(1);
   localparam logic [SH_W-1:0]  SH_MAX   = SH_W'(MAN_W);

   logic [1:0]       state_q, state_d;
   logic             sign_q, sign_d;
   logic [EXP_W:0]   exp_q, exp_d;
   logic [MAN_W+1:0] mant_q, mant_d;
   logic [2:0]       grs_q, grs_d;
   logic [SH_W-1:0]  shift_q, shift_d;
   logic [RES_W-1:0] result_q, result_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             inx_q, inx_d;

   logic             round_up;
   logic             rnd_inexact;
   logic [MAN_W+1:0] rnd_sum;
   logic [MAN_W:0]   rnd_mant;
   logic [EXP_W:0]   rnd_exp;
   logic [EXP_W:0]   enc_exp;
   logic [RES_W-1:0] ovf_result;

   // Rounding datapath, consumed only in ROUND; a carry out of the significand renormalizes by one.
   always_comb begin
      rnd_inexact = |grs_q;
`ifdef POST_NORMAL_RNE_EN
      round_up   = grs_q[2] & (grs_q[1] | grs_q[0] | mant_q[0]);
      ovf_result = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
`else
      round_up   = 1'b0;
      ovf_result = {sign_q, {{(EXP_W-1){1'b1}}, 1'b0}, {MAN_W{1'b1}}};
`endif
      rnd_sum = {1'b0, mant_q[MAN_W:0]} + {{(MAN_W+1){1'b0}}, round_up};
      if (rnd_sum[MAN_W+1]) begin
         rnd_mant = rnd_sum[MAN_W+1:1];
         rnd_exp  = exp_q + 1'b1;
      end else begin
         rnd_mant = rnd_sum[MAN_W:0];
         rnd_exp  = exp_q;
      end
      enc_exp = rnd_mant[MAN_W] ? rnd_exp : '0;
   end

   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      mant_d   = mant_q;
      grs_d    = grs_q;
      shift_d  = shift_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      inx_d    = inx_q;
      case (state_q)
         S_IDLE: begin
            if (valid_i) begin
               sign_d  = sign_i;
               exp_d   = {1'b0, exp_i};
               mant_d  = mant_i;
               grs_d   = grs_i;
               shift_d = '0;
               state_d = S_NORM;
            end
         end
         S_NORM: begin
            if (exp_q == EXP_MAX) begin
               result_d = {sign_q, EXP_ONES, mant_q[MAN_W-1:0]};
               ovf_d    = 1'b0;
               unf_d    = 1'b0;
               inx_d    = 1'b0;
               state_d  = S_DONE;
            end else if (mant_q == '0 && grs_q == 3'b000) begin
               result_d = '0;
               ovf_d    = 1'b0;
               unf_d    = 1'b0;
               inx_d    = 1'b0;
               state_d  = S_DONE;
            end else if (mant_q[MAN_W+1]) begin
               mant_d  = {1'b0, mant_q[MAN_W+1:1]};
               exp_d   = exp_q + 1'b1;
               grs_d   = {mant_q[0], grs_q[2], grs_q[1] | grs_q[0]};
               state_d = S_ROUND;
            end else if (mant_q[MAN_W] || exp_q <= EXP_ONE || shift_q == SH_MAX) begin
               state_d = S_ROUND;
            end else begin
               // Guard bit feeds the vacated LSB; sticky is preserved across left shifts.
               mant_d  = {mant_q[MAN_W:0], grs_q[2]};
               exp_d   = exp_q - 1'b1;
               grs_d   = {grs_q[1], 1'b0, grs_q[0]};
               shift_d = shift_q + 1'b1;
            end
         end
         S_ROUND: begin
            if (enc_exp >= EXP_MAX) begin
               result_d = ovf_result;
               ovf_d    = 1'b1;
               unf_d    = 1'b0;
               inx_d    = 1'b1;
            end else begin
               result_d = {sign_q, enc_exp[EXP_W-1:0], rnd_mant[MAN_W-1:0]};
               ovf_d    = 1'b0;
               unf_d    = (enc_exp == '0) & rnd_inexact;
               inx_d    = rnd_inexact;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            if (ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         mant_q   <= '0;
         grs_q    <= 3'b000;
         shift_q  <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         inx_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         mant_q   <= mant_d;
         grs_q    <= grs_d;
         shift_q  <= shift_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         inx_q    <= inx_d;
      end
   end

   assign ready_o     = (state_q == S_IDLE);
   assign valid_o     = (state_q == S_DONE);
   assign result_o    = result_q;
   assign overflow_o  = ovf_q;
   assign underflow_o = unf_q;
   assign inexact_o   = inx_q;

endmodule

// File: tb/tb_post_normal.sv
// Self-checking bench for post_normal: directed vectors, stall/reset sequences and
// randomized operations against an arithmetic reference model.
module tb_post_normal;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic        sign_i;
   logic [7:0]  exp_i;
   logic [24:0] mant_i;
   logic [2:0]  grs_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] result_o;
   logic        overflow_o;
   logic        underflow_o;
   logic        inexact_o;

`ifdef POST_NORMAL_RNE_EN
   localparam bit RNE = 1'b1;
`else
   localparam bit RNE = 1'b0;
`endif

   typedef struct {
      logic        sign;
      logic [7:0]  exp;
      logic [24:0] mant;
      logic [2:0]  grs;
   } op_t;

   typedef struct {
      logic [31:0] result;
      logic [2:0]  flags;
      int          lat;
   } ref_t;

   typedef struct {
      logic        sign;
      logic [7:0]  exp;
      logic [24:0] mant;
      logic [2:0]  grs;
      logic [31:0] res_rne;
      logic [31:0] res_rtz;
      logic [2:0]  flg_rne;
      logic [2:0]  flg_rtz;
      int          lat;
   } vec_t;

   int n_checks = 0;
   int n_pass   = 0;

   post_normal dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .sign_i      (sign_i),
      .exp_i       (exp_i),
      .mant_i      (mant_i),
      .grs_i       (grs_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .result_o    (result_o),
      .overflow_o  (overflow_o),
      .underflow_o (underflow_o),
      .inexact_o   (inexact_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference: value-level renormalize/round using integer arithmetic on the significand.
   function automatic ref_t model(input op_t op);
      ref_t        o;
      longint      m;
      int          e, g, r, s, k, rem, enc;
      bit          up, inx;
      logic [22:0] frac;
      logic [7:0]  eb;
      m = longint'(op.mant);
      e = int'(op.exp);
      g = int'(op.grs[2]);
      r = int'(op.grs[1]);
      s = int'(op.grs[0]);
      k = 0;
      o.flags = 3'b000;
      o.lat   = 2;
      if (e == 255) begin
         o.result = {op.sign, 8'hFF, op.mant[22:0]};
         return o;
      end
      if (m == 0 && op.grs == 3'b000) begin
         o.result = 32'h0;
         return o;
      end
      if (m >= 64'd16777216) begin
         s = s | r;
         r = g;
         g = int'(m % 2);
         m = m / 2;
         e++;
      end else begin
         while (m < 64'd8388608 && e > 1 && k < 23) begin
            m = m * 2 + longint'(g);
            g = r;
            r = 0;
            e--;
            k++;
         end
      end
      rem = 4 * g + 2 * r + s;
      up  = RNE && (rem > 4 || (rem == 4 && (m % 2) == 1));
      inx = (rem != 0);
      m   = m + longint'(up);
      if (m == 64'd16777216) begin
         m = m / 2;
         e++;
      end
      enc   = (m >= 64'd8388608) ? e : 0;
      o.lat = 3 + k;
      if (enc >= 255) begin
         o.flags  = 3'b101;
         o.result = RNE ? {op.sign, 8'hFF, 23'h0} : {op.sign, 8'hFE, 23'h7FFFFF};
      end else begin
         frac     = m[22:0];
         eb       = enc[7:0];
         o.result = {op.sign, eb, frac};
         o.flags  = {1'b0, (enc == 0) && inx, inx};
      end
      return o;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
   endtask

   // Presents one operand bundle, waits for acceptance and then for valid_o; returns edge count.
   task automatic applyStimulus(input op_t op, output int lat);
      int w;
      @(negedge clk_i);
      sign_i  = op.sign;
      exp_i   = op.exp;
      mant_i  = op.mant;
      grs_i   = op.grs;
      valid_i = 1'b1;
      w = 0;
      while (!ready_o && w < 20) begin
         @(negedge clk_i);
         w++;
      end
      @(posedge clk_i);
      lat = 1;
      #1;
      valid_i = 1'b0;
      while (!valid_o && lat < 60) begin
         @(posedge clk_i);
         lat++;
         #1;
      end
   endtask

   task automatic runOp(input op_t op, input logic [31:0] req_res, input logic [2:0] req_flg,
                        input int req_lat, input string tag);
      int lat;
      applyStimulus(op, lat);
      checkOutput({tag, " latency"}, 32'(lat), 32'(req_lat));
      checkOutput({tag, " result"}, result_o, req_res);
      checkOutput({tag, " flags"}, {29'h0, overflow_o, underflow_o, inexact_o}, {29'h0, req_flg});
      @(negedge clk_i);
      ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      checkOutput({tag, " handshake valid/ready"}, {30'h0, valid_o, ready_o}, 32'h1);
      ready_i = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t vecs[12];
      op_t  op;
      ref_t rf;
      int   lat;

      vecs[0]  = '{1'b0, 8'h7F, 25'h1000000, 3'b000, 32'h40000000, 32'h40000000, 3'b000, 3'b000, 3};
      vecs[1]  = '{1'b0, 8'h80, 25'h0400000, 3'b000, 32'h3F800000, 32'h3F800000, 3'b000, 3'b000, 4};
      vecs[2]  = '{1'b0, 8'h7F, 25'h0800001, 3'b100, 32'h3F800002, 32'h3F800001, 3'b001, 3'b001, 3};
      vecs[3]  = '{1'b0, 8'h7F, 25'h0800000, 3'b100, 32'h3F800000, 32'h3F800000, 3'b001, 3'b001, 3};
      vecs[4]  = '{1'b0, 8'hFE, 25'h1000000, 3'b000, 32'h7F800000, 32'h7F7FFFFF, 3'b101, 3'b101, 3};
      vecs[5]  = '{1'b1, 8'h55, 25'h0000000, 3'b000, 32'h00000000, 32'h00000000, 3'b000, 3'b000, 2};
      vecs[6]  = '{1'b1, 8'hFF, 25'h0400001, 3'b111, 32'hFFC00001, 32'hFFC00001, 3'b000, 3'b000, 2};
      vecs[7]  = '{1'b0, 8'h01, 25'h0400000, 3'b000, 32'h00400000, 32'h00400000, 3'b000, 3'b000, 3};
      vecs[8]  = '{1'b0, 8'h01, 25'h07FFFFF, 3'b110, 32'h00800000, 32'h007FFFFF, 3'b001, 3'b011, 3};
      vecs[9]  = '{1'b0, 8'h7F, 25'h1FFFFFF, 3'b000, 32'h40800000, 32'h407FFFFF, 3'b001, 3'b001, 3};
      vecs[10] = '{1'b0, 8'h80, 25'h0400000, 3'b100, 32'h3F800001, 32'h3F800001, 3'b000, 3'b000, 4};
      vecs[11] = '{1'b0, 8'h03, 25'h0000010, 3'b000, 32'h00000040, 32'h00000040, 3'b000, 3'b000, 5};

      rst_i   = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b0;
      sign_i  = 1'b0;
      exp_i   = 8'h0;
      mant_i  = 25'h0;
      grs_i   = 3'b000;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("reset result", result_o, 32'h0);
      checkOutput("reset valid/ready/flags",
                  {27'h0, valid_o, ready_o, overflow_o, underflow_o, inexact_o}, 32'h08);
      rst_i = 1'b0;

      for (int i = 0; i < 12; i++) begin
         op = '{vecs[i].sign, vecs[i].exp, vecs[i].mant, vecs[i].grs};
         runOp(op, RNE ? vecs[i].res_rne : vecs[i].res_rtz,
               RNE ? vecs[i].flg_rne : vecs[i].flg_rtz, vecs[i].lat, $sformatf("vec%0d", i));
      end

      // Stall in DONE: outputs must hold while ready_i stays low.
      op = '{1'b0, 8'h7F, 25'h0800001, 3'b100};
      applyStimulus(op, lat);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i);
         checkOutput($sformatf("stall%0d result", c), result_o, RNE ? 32'h3F800002 : 32'h3F800001);
         checkOutput($sformatf("stall%0d valid/ready/flags", c),
                     {27'h0, valid_o, ready_o, overflow_o, underflow_o, inexact_o}, 32'h11);
      end
      // New operand waiting during the handshake edge must not be taken on that edge.
      sign_i  = 1'b0;
      exp_i   = 8'h20;
      mant_i  = 25'h0;
      grs_i   = 3'b000;
      valid_i = 1'b1;
      ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      checkOutput("handshake-edge no accept", {30'h0, valid_o, ready_o}, 32'h1);
      ready_i = 1'b0;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      checkOutput("post-handshake zero op valid", {31'h0, valid_o}, 32'h1);
      checkOutput("post-handshake zero op result", result_o, 32'h0);
      @(negedge clk_i);
      ready_i = 1'b1;
      @(negedge clk_i);
      ready_i = 1'b0;

      // Asynchronous reset while shifting in NORM discards the operation.
      sign_i  = 1'b1;
      exp_i   = 8'h80;
      mant_i  = 25'h0000001;
      grs_i   = 3'b000;
      valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("mid-NORM busy", {31'h0, ready_o}, 32'h0);
      rst_i = 1'b1;
      #1;
      checkOutput("mid-NORM reset valid/ready", {30'h0, valid_o, ready_o}, 32'h1);
      checkOutput("mid-NORM reset result", result_o, 32'h0);
      @(negedge clk_i);
      rst_i = 1'b0;
      op = '{vecs[0].sign, vecs[0].exp, vecs[0].mant, vecs[0].grs};
      runOp(op, 32'h40000000, 3'b000, 3, "after-reset");

      for (int i = 0; i < 80; i++) begin
         op.sign = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       op.exp = 8'($urandom);
            1:       op.exp = 8'($urandom_range(0, 4));
            2:       op.exp = 8'($urandom_range(250, 255));
            default: op.exp = 8'($urandom_range(100, 150));
         endcase
         case ($urandom_range(0, 4))
            0:       op.mant = {1'b1, 24'($urandom)};
            1:       op.mant = {2'b01, 23'($urandom)};
            2:       op.mant = 25'($urandom) >> $urandom_range(2, 24);
            3:       op.mant = 25'h0;
            default: op.mant = 25'($urandom);
         endcase
         op.grs = 3'($urandom);
         rf = model(op);
         runOp(op, rf.result, rf.flags, rf.lat, $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
